rdma_pkt_validator: RTL and testbench
=====================================

RDMA_PKT_VALIDATOR -- requirements
Module: rdma_pkt_validator

Interface
REQ-001 SHALL have parameter DATA_WBITS, default 512, meaning stream data width in bits.
REQ-002 SHALL have parameter DATA_WBYTS, default DATA_WBITS/8, meaning TKEEP width.
REQ-003 SHALL have parameter MAX_BEATS, default 64, legal range 2..65535, meaning maximum legal beats per packet.
REQ-004 SHALL have ports: clk  in  1  clock; resetn  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: AXIS_IN_TDATA  in  DATA_WBITS  input data; AXIS_IN_TKEEP  in  DATA_WBYTS  byte enables; AXIS_IN_TUSER  in  1  upstream (MAC) error flag, sampled on the TLAST beat; AXIS_IN_TLAST  in  1; AXIS_IN_TVALID  in  1; AXIS_IN_TREADY  out  1.
REQ-006 SHALL have ports: AXIS_OUT_TDATA  out  DATA_WBITS; AXIS_OUT_TKEEP  out  DATA_WBYTS; AXIS_OUT_TUSER  out  1  bad-packet flag, meaningful only on the TLAST beat; AXIS_OUT_TLAST  out  1; AXIS_OUT_TVALID  out  1; AXIS_OUT_TREADY  in  1.
REQ-007 SHALL have ports: pkt_count  out  32  packets emitted; bad_count  out  32  packets emitted with TUSER=1; oversize  out  1  sticky, at least one packet truncated.

Function
REQ-008 SHALL pass each input beat to a single output register; latency 1 cycle from input handshake to AXIS_OUT_TVALID.
REQ-009 SHALL drive AXIS_IN_TREADY = ~AXIS_OUT_TVALID | AXIS_OUT_TREADY when not in DISCARD, and 1 in DISCARD.
REQ-010 SHALL hold the output register stable while AXIS_OUT_TVALID=1 and AXIS_OUT_TREADY=0.
REQ-011 SHALL have states FIRST (next beat is packet header), BODY, DISCARD.
REQ-012 SHALL, on a FIRST-state handshake, latch expected = TDATA[15:0] (header beat-count field, header beat included) and set beat count to 1.
REQ-013 SHALL, on each BODY handshake, increment beat count; the counter SHALL be clog2(MAX_BEATS)+1 bits wide and never wrap.
REQ-014 SHALL, on an input TLAST beat, output TLAST=1 and TUSER = AXIS_IN_TUSER | (beat count incl. this beat != expected), then enter FIRST.
REQ-015 SHALL treat a header field of 0 as a mismatch; a single-beat packet is good only if the field equals 1 and AXIS_IN_TUSER=0.
REQ-016 SHALL, when beat MAX_BEATS is accepted without TLAST, output it with TLAST=1, TUSER=1, set oversize, and enter DISCARD.
REQ-017 SHALL, in DISCARD, accept and drop all input beats without output, returning to FIRST after the beat carrying TLAST.
REQ-018 SHALL treat a header field greater than MAX_BEATS as already mismatched; truncation per REQ-016 still applies.
REQ-019 SHALL increment pkt_count on each output TLAST handshake, and bad_count on each such handshake with TUSER=1; both saturate at 0xFFFFFFFF.
REQ-020 SHALL, with TLAST on exactly beat MAX_BEATS, emit a normal end per REQ-014 (no DISCARD, oversize unchanged).

Reset
REQ-021 SHALL, while resetn=0 at a clk edge, set AXIS_OUT_TVALID=0, state=FIRST, pkt_count=0, bad_count=0, oversize=0; AXIS_OUT_TDATA/TKEEP/TUSER/TLAST SHALL be 0.
REQ-022 SHALL drive AXIS_IN_TREADY=0 during reset.
REQ-023 SHALL, on reset mid-packet, discard any partial packet; first beat after reset release SHALL be parsed as a header.

Verification
REQ-024 3-beat packet, header field 3, TUSER_in=0, OUT_TREADY=1 -> 3 output beats 1 cycle later, TLAST on beat 3, TUSER=0, pkt_count=1, bad_count=0.
REQ-025 3-beat packet, header field 4 -> TUSER=1 on beat 3, bad_count=1; next packet, header field 1, single beat with TUSER_in=1 -> TUSER=1, bad_count=2.
REQ-026 MAX_BEATS=4, 7-beat packet -> 4 output beats, beat 4 TLAST=1 TUSER=1, beats 5-7 accepted and dropped, oversize=1; following 2-beat good packet passes unmodified.
REQ-027 Toggle OUT_TREADY 0/1 every cycle across 10 back-to-back packets -> no beat lost/duplicated, output data held stable while stalled, pkt_count=10.
REQ-028 Assert resetn=0 after beat 2 of a 5-beat packet, release, send 2-beat packet header field 2 -> outputs only the 2-beat packet, TUSER=0, pkt_count=1.

Source files
------------

// File: rtl/rdma_pkt_validator_if.sv
// ---------------------------------------------------------------------------
// rdma_pkt_validator_if
// AXI4-Stream bundle used on both sides of rdma_pkt_validator.
//   TDATA  [DATA_WBITS-1:0] payload
//   TKEEP  [DATA_WBYTS-1:0] byte enables
//   TUSER                   error flag (valid on the TLAST beat)
//   TLAST                   end of packet
//   TVALID / TREADY         handshake
// master drives everything except TREADY; slave drives only TREADY.
// ---------------------------------------------------------------------------
interface rdma_pkt_validator_if #(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8
);
    logic [DATA_WBITS-1:0] TDATA;
    logic [DATA_WBYTS-1:0] TKEEP;
    logic                  TUSER;
    logic                  TLAST;
    logic                  TVALID;
    logic                  TREADY;

    modport master (
        output TDATA,
        output TKEEP,
        output TUSER,
        output TLAST,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TKEEP,
        input  TUSER,
        input  TLAST,
        input  TVALID,
        output TREADY
    );
endinterface

// File: rtl/rdma_pkt_validator.sv
// ---------------------------------------------------------------------------
// rdma_pkt_validator
// Checks the beat count of each packet against the 16-bit beat-count field
// carried in TDATA[15:0] of the header (first) beat, flags mismatches and
// upstream errors on the output TUSER of the TLAST beat, and truncates
// packets longer than MAX_BEATS (remaining beats are dropped).
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   AXIS_IN  (slave)  input stream, TUSER = upstream MAC error on TLAST beat
//   AXIS_OUT (master) output stream, TUSER = bad-packet flag on TLAST beat
//   pkt_count         packets emitted (saturating)
//   bad_count         packets emitted with TUSER=1 (saturating)
//   oversize          sticky: at least one packet was truncated
// ---------------------------------------------------------------------------
module rdma_pkt_validator #(
    parameter int DATA_WBITS = 512,
    parameter int DATA_WBYTS = DATA_WBITS / 8,
    parameter int MAX_BEATS  = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    rdma_pkt_validator_if.slave  AXIS_IN,
    rdma_pkt_validator_if.master AXIS_OUT,
    output logic [31:0]          pkt_count,
    output logic [31:0]          bad_count,
    output logic                 oversize
);
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_BODY,
        ST_DISCARD
    } state_t;

    state_t                  state_reg, state_next;
    logic [15:0]             expected_reg, expected_next;
    logic [CNT_W-1:0]        beat_reg, beat_next;
    logic [DATA_WBITS-1:0]   out_data_reg, out_data_next;
    logic [DATA_WBYTS-1:0]   out_keep_reg, out_keep_next;
    logic                    out_user_reg, out_user_next;
    logic                    out_last_reg, out_last_next;
    logic                    out_valid_reg, out_valid_next;
    logic [31:0]             pkt_count_reg, pkt_count_next;
    logic [31:0]             bad_count_reg, bad_count_next;
    logic                    oversize_reg, oversize_next;

    logic                    in_ready;
    logic                    in_fire;
    logic                    out_fire;
    logic [CNT_W-1:0]        beat_inc;   // beat count including the current input beat
    logic [15:0]             hdr_len;    // expected length for the current packet
    logic                    len_bad;
    logic                    trunc;

    always_comb begin
        // DISCARD sinks input regardless of the output side; TREADY is held
        // low while reset is asserted.
        in_ready = resetn & ((state_reg == ST_DISCARD) | ~out_valid_reg | AXIS_OUT.TREADY);
        in_fire  = in_ready & AXIS_IN.TVALID;
        out_fire = out_valid_reg & AXIS_OUT.TREADY;

        beat_inc = (state_reg == ST_FIRST) ? CNT_W'(1) : beat_reg + CNT_W'(1);
        hdr_len  = (state_reg == ST_FIRST) ? AXIS_IN.TDATA[15:0] : expected_reg;
        // A header of 0 or above MAX_BEATS can never equal a reachable count,
        // so those fall out of this compare as mismatches without extra logic.
        len_bad  = (32'(beat_inc) != 32'(hdr_len));
        trunc    = ~AXIS_IN.TLAST & (beat_inc == CNT_W'(MAX_BEATS));
    end

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        beat_next      = beat_reg;
        out_data_next  = out_data_reg;
        out_keep_next  = out_keep_reg;
        out_user_next  = out_user_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        pkt_count_next = pkt_count_reg;
        bad_count_next = bad_count_reg;
        oversize_next  = oversize_reg;

        if (out_fire) begin
            out_valid_next = 1'b0;
        end

        unique case (state_reg)
            ST_FIRST, ST_BODY: begin
                if (in_fire) begin
                    out_valid_next = 1'b1;
                    out_data_next  = AXIS_IN.TDATA;
                    out_keep_next  = AXIS_IN.TKEEP;
                    beat_next      = beat_inc;
                    expected_next  = hdr_len;
                    if (AXIS_IN.TLAST) begin
                        out_last_next = 1'b1;
                        out_user_next = AXIS_IN.TUSER | len_bad;
                        state_next    = ST_FIRST;
                    end else if (trunc) begin
                        // Close the packet early and swallow its tail.
                        out_last_next = 1'b1;
                        out_user_next = 1'b1;
                        oversize_next = 1'b1;
                        state_next    = ST_DISCARD;
                    end else begin
                        out_last_next = 1'b0;
                        out_user_next = 1'b0;
                        state_next    = ST_BODY;
                    end
                end
            end
            ST_DISCARD: begin
                if (in_fire && AXIS_IN.TLAST) begin
                    state_next = ST_FIRST;
                end
            end
            default: state_next = ST_FIRST;
        endcase

        if (out_fire && out_last_reg) begin
            if (pkt_count_reg != 32'hFFFF_FFFF) begin
                pkt_count_next = pkt_count_reg + 32'd1;
            end
            if (out_user_reg && (bad_count_reg != 32'hFFFF_FFFF)) begin
                bad_count_next = bad_count_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_FIRST;
            expected_reg  <= '0;
            beat_reg      <= '0;
            out_data_reg  <= '0;
            out_keep_reg  <= '0;
            out_user_reg  <= 1'b0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            pkt_count_reg <= '0;
            bad_count_reg <= '0;
            oversize_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            beat_reg      <= beat_next;
            out_data_reg  <= out_data_next;
            out_keep_reg  <= out_keep_next;
            out_user_reg  <= out_user_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
            pkt_count_reg <= pkt_count_next;
            bad_count_reg <= bad_count_next;
            oversize_reg  <= oversize_next;
        end
    end

    assign AXIS_IN.TREADY  = in_ready;
    assign AXIS_OUT.TDATA  = out_data_reg;
    assign AXIS_OUT.TKEEP  = out_keep_reg;
    assign AXIS_OUT.TUSER  = out_user_reg;
    assign AXIS_OUT.TLAST  = out_last_reg;
    assign AXIS_OUT.TVALID = out_valid_reg;
    assign pkt_count       = pkt_count_reg;
    assign bad_count       = bad_count_reg;
    assign oversize        = oversize_reg;
endmodule

// File: tb/tb_rdma_pkt_validator.sv
// ---------------------------------------------------------------------------
// tb_rdma_pkt_validator
// Directed packet stimulus with a packet-level expectation queue. For each
// packet sent, the expected output beats are derived from its length, header
// field, MAC error flag and MAX_BEATS; a negedge monitor compares every output
// handshake, output stability while stalled and the counters against that
// model. Literal counter values pin the model at idle points.
// ---------------------------------------------------------------------------
module tb_rdma_pkt_validator;
    localparam int DW = 32;
    localparam int DB = 4;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [DB-1:0] keep;
        logic          last;
        logic          user;
    } beat_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] pkt_count;
    logic [31:0] bad_count;
    logic        oversize;

    always #5 clk = ~clk;

    rdma_pkt_validator_if #(.DATA_WBITS(DW), .DATA_WBYTS(DB)) s_in ();
    rdma_pkt_validator_if #(.DATA_WBITS(DW), .DATA_WBYTS(DB)) s_out ();

    rdma_pkt_validator #(
        .DATA_WBITS(DW),
        .DATA_WBYTS(DB),
        .MAX_BEATS (MB)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .AXIS_IN  (s_in.slave),
        .AXIS_OUT (s_out.master),
        .pkt_count(pkt_count),
        .bad_count(bad_count),
        .oversize (oversize)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    mdl_pkt = 0;
    int    mdl_bad = 0;
    int    ready_mode = 0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output-side ready: constant 1, or toggling every cycle.
    initial begin
        s_out.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) s_out.TREADY = ~s_out.TREADY;
            else                 s_out.TREADY = 1'b1;
        end
    end

    // Monitor: compares each output handshake and the counters to the model.
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{data: s_out.TDATA, keep: s_out.TKEEP, last: s_out.TLAST, user: s_out.TUSER};
        if (!resetn) begin
            mdl_pkt    = 0;
            mdl_bad    = 0;
            prev_stall = 1'b0;
            exp_q.delete();
        end else begin
            check("pkt_count", 64'(pkt_count), 64'(mdl_pkt));
            check("bad_count", 64'(bad_count), 64'(mdl_bad));
            if (prev_stall) begin
                check("stall_valid", 64'(s_out.TVALID), 64'd1);
                check("stall_hold", 64'(cur), 64'(prev_beat));
            end
            if (s_out.TVALID && s_out.TREADY) begin
                $display("out beat data=%08h keep=%h last=%0d user=%0d", cur.data, cur.keep, cur.last, cur.user);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %08h expected no beat", cur.data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(cur.data), 64'(e.data));
                    check("out_keep", 64'(cur.keep), 64'(e.keep));
                    check("out_last", 64'(cur.last), 64'(e.last));
                    if (e.last) begin
                        check("out_user", 64'(cur.user), 64'(e.user));
                        mdl_pkt = mdl_pkt + 1;
                        if (e.user) mdl_bad = mdl_bad + 1;
                    end
                end
            end
            prev_stall = s_out.TVALID & ~s_out.TREADY;
            prev_beat  = cur;
        end
    end

    // Drive one beat starting at posedge+1; returns at posedge+1 after accept.
    task automatic send_beat(input logic [DW-1:0] d, input logic [DB-1:0] k,
                             input logic l, input logic u);
        int   t;
        logic r;
        bit   done;
        s_in.TDATA  = d;
        s_in.TKEEP  = k;
        s_in.TLAST  = l;
        s_in.TUSER  = u;
        s_in.TVALID = 1'b1;
        t = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            r = s_in.TREADY;
            @(posedge clk);
            if (r) done = 1;
            else begin
                t++;
                if (t > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL in_accept: got no TREADY within 200 cycles, expected accept");
                    done = 1;
                end
            end
        end
        #1;
        s_in.TVALID = 1'b0;
    endtask

    function automatic logic [DW-1:0] beat_data(input int i, input logic [15:0] hdr, input logic [15:0] tag);
        return (i == 0) ? {tag, hdr} : {tag, 16'(i * 16'h1111)};
    endfunction

    // Send an n-beat packet; only the first 'stop' beats are sent (stop < n
    // models an aborted packet). Expected output derives from packet rules.
    task automatic send_pkt(input int n, input logic [15:0] hdr, input logic mac_err,
                            input logic [15:0] tag, input int stop);
        int    out_n;
        bit    bad;
        beat_t b;
        logic [DB-1:0] k;
        out_n = (stop < n) ? stop : ((n > MB) ? MB : n);
        bad   = (n > MB) || mac_err || (32'(hdr) != n);
        for (int i = 0; i < out_n; i++) begin
            k      = (i == n - 1) ? 4'b0011 : 4'b1111;
            b.data = beat_data(i, hdr, tag);
            b.keep = k;
            b.last = (stop >= n) && (i == out_n - 1);
            b.user = b.last ? bad : 1'b0;
            exp_q.push_back(b);
        end
        for (int i = 0; i < stop && i < n; i++) begin
            k = (i == n - 1) ? 4'b0011 : 4'b1111;
            send_beat(beat_data(i, hdr, tag), k, (i == n - 1), (i == n - 1) ? mac_err : 1'b0);
        end
    endtask

    // Wait (bounded) until the model is drained and the output is empty;
    // returns at a negedge.
    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (((exp_q.size() != 0) || s_out.TVALID) && t < 500);
        if (t >= 500) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic to_drive_slot();
        @(posedge clk);
        #1;
    endtask

    // 10 back-to-back packets under toggling output ready.
    int          bb_n  [10] = '{1, 2, 3, 4, 2, 3, 1, 4, 6, 2};
    logic [15:0] bb_hdr[10] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd2, 16'd3, 16'd1, 16'd4, 16'd6, 16'd2};
    logic        bb_err[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        beat_t b;
        s_in.TDATA  = '0;
        s_in.TKEEP  = '0;
        s_in.TLAST  = 1'b0;
        s_in.TUSER  = 1'b0;
        s_in.TVALID = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(s_in.TREADY), 64'd0);
        check("rst_out_valid", 64'(s_out.TVALID), 64'd0);
        check("rst_out_data", 64'(s_out.TDATA), 64'd0);
        check("rst_out_last", 64'(s_out.TLAST), 64'd0);
        check("rst_out_user", 64'(s_out.TUSER), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        check("rst_bad", 64'(bad_count), 64'd0);
        check("rst_oversize", 64'(oversize), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        to_drive_slot();

        // Good 3-beat packet with literal expectations; 1-cycle latency.
        b = '{data: 32'hA001_0003, keep: 4'hF, last: 1'b0, user: 1'b0}; exp_q.push_back(b);
        b = '{data: 32'hA001_1111, keep: 4'hF, last: 1'b0, user: 1'b0}; exp_q.push_back(b);
        b = '{data: 32'hA001_2222, keep: 4'h3, last: 1'b1, user: 1'b0}; exp_q.push_back(b);
        send_beat(32'hA001_0003, 4'hF, 1'b0, 1'b0);
        check("latency_valid", 64'(s_out.TVALID), 64'd1);
        check("latency_data", 64'(s_out.TDATA), 64'hA001_0003);
        send_beat(32'hA001_1111, 4'hF, 1'b0, 1'b0);
        send_beat(32'hA001_2222, 4'h3, 1'b1, 1'b0);
        wait_idle();
        check("t1_pkt", 64'(pkt_count), 64'd1);
        check("t1_bad", 64'(bad_count), 64'd0);
        to_drive_slot();

        // Length mismatch, then single-beat with MAC error.
        send_pkt(3, 16'd4, 1'b0, 16'hB002, 99);
        send_pkt(1, 16'd1, 1'b1, 16'hB003, 99);
        wait_idle();
        check("t2_pkt", 64'(pkt_count), 64'd3);
        check("t2_bad", 64'(bad_count), 64'd2);
        to_drive_slot();

        // Good single beat, header 0, header above MAX_BEATS, exactly MAX_BEATS.
        send_pkt(1, 16'd1, 1'b0, 16'hC004, 99);
        send_pkt(2, 16'd0, 1'b0, 16'hC005, 99);
        send_pkt(3, 16'd9, 1'b0, 16'hC006, 99);
        send_pkt(4, 16'd4, 1'b0, 16'hC007, 99);
        wait_idle();
        check("t3_pkt", 64'(pkt_count), 64'd7);
        check("t3_bad", 64'(bad_count), 64'd4);
        check("t3_oversize", 64'(oversize), 64'd0);
        to_drive_slot();

        // 7-beat packet truncated to 4, then a good 2-beat packet.
        send_pkt(7, 16'd7, 1'b0, 16'hD008, 99);
        send_pkt(2, 16'd2, 1'b0, 16'hD009, 99);
        wait_idle();
        check("t4_pkt", 64'(pkt_count), 64'd9);
        check("t4_bad", 64'(bad_count), 64'd5);
        check("t4_oversize", 64'(oversize), 64'd1);
        to_drive_slot();

        // 10 back-to-back packets with toggling output ready.
        ready_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send_pkt(bb_n[i], bb_hdr[i], bb_err[i], 16'(16'hE000 + i), 99);
        end
        wait_idle();
        ready_mode = 0;
        check("t5_pkt", 64'(pkt_count), 64'd19);
        check("t5_bad", 64'(bad_count), 64'd8);
        to_drive_slot();

        // Reset after beat 2 of a 5-beat packet, then a good 2-beat packet.
        send_pkt(5, 16'd5, 1'b0, 16'hF00A, 2);
        wait_idle();
        to_drive_slot();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_rst_ready", 64'(s_in.TREADY), 64'd0);
        check("t6_rst_pkt", 64'(pkt_count), 64'd0);
        check("t6_rst_oversize", 64'(oversize), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        to_drive_slot();
        send_pkt(2, 16'd2, 1'b0, 16'hF00B, 99);
        wait_idle();
        check("t6_pkt", 64'(pkt_count), 64'd1);
        check("t6_bad", 64'(bad_count), 64'd0);
        check("t6_oversize", 64'(oversize), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
